// File: rtl/found_scheduler_if.sv
// Report handshake between the found scheduler and the UART serializer:
// one captured coefficient slice plus the index of the module that produced it.
interface found_scheduler_if #(
  parameter int W     = 64,
  parameter int IDX_W = 6
);
  logic [W-1:0]     tx_data;
  logic [IDX_W-1:0] tx_idx;
  logic             tx_valid;
  logic             tx_ready;

  modport master (output tx_data, output tx_idx, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_idx, input tx_valid, output tx_ready);
endinterface

// File: rtl/found_scheduler.sv
// Round-robin scheduler that shares the single UART report path between the
// search modules: grants one found flag, forwards its slice, then releases it.
module found_scheduler #(
  parameter int NUM_OF_TAPS    = 8,
  parameter int NUM_OF_MODULES = 30,
  parameter int IDX_W          = 6,
  parameter int CLR_TIMEOUT    = 255
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_OF_MODULES-1:0]               found,
  input  logic [NUM_OF_MODULES*NUM_OF_TAPS*8-1:0] co_buf,
  output logic [NUM_OF_MODULES-1:0]               res,
  found_scheduler_if.master                       tx,
  output logic                                    busy,
  output logic [15:0]                             report_cnt,
  output logic                                    clr_err
);
  localparam int N     = NUM_OF_MODULES;
  localparam int W     = NUM_OF_TAPS * 8;
  localparam int TMR_W = $clog2(CLR_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLR_TIMEOUT - 1);
  localparam logic [N-1:0]     ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    RELEASE  = 2'd2,
    WAIT_CLR = 2'd3
  } state_t;

  state_t           state_r;
  logic [IDX_W-1:0] ptr_r;
  logic [N-1:0]     mask_r;
  logic [TMR_W-1:0] timer_r;
  logic [N-1:0]     res_r;
  logic [W-1:0]     tx_data_r;
  logic [IDX_W-1:0] tx_idx_r;
  logic             tx_valid_r;
  logic             busy_r;
  logic [15:0]      report_cnt_r;
  logic             clr_err_r;

  logic [N-1:0]     req_s;
  logic             hi_vld_s;
  logic             lo_vld_s;
  logic [IDX_W-1:0] hi_idx_s;
  logic [IDX_W-1:0] lo_idx_s;
  logic             grant_vld_s;
  logic [IDX_W-1:0] grant_s;
  logic [W-1:0]     slice_s;
  logic             found_g_s;

  // Round-robin pick: lowest requester above ptr, otherwise the lowest overall (wrap)
  always_comb begin
    req_s    = found & ~mask_r;
    hi_vld_s = 1'b0;
    lo_vld_s = 1'b0;
    hi_idx_s = {IDX_W{1'b0}};
    lo_idx_s = {IDX_W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      lo_vld_s = lo_vld_s | req_s[i];
      lo_idx_s = req_s[i] ? IDX_W'(i) : lo_idx_s;
      hi_vld_s = hi_vld_s | (req_s[i] && (IDX_W'(i) > ptr_r));
      hi_idx_s = (req_s[i] && (IDX_W'(i) > ptr_r)) ? IDX_W'(i) : hi_idx_s;
    end
    grant_vld_s = lo_vld_s;
    grant_s     = hi_vld_s ? hi_idx_s : lo_idx_s;
  end

  // Slice of the candidate winner and found flag of the currently granted module
  always_comb begin
    slice_s   = {W{1'b0}};
    found_g_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      slice_s   = (IDX_W'(i) == grant_s)  ? co_buf[i*W +: W] : slice_s;
      found_g_s = (IDX_W'(i) == tx_idx_r) ? found[i]         : found_g_s;
    end
  end

  // Scheduler FSM: capture, handshake, release pulse and clear-wait with timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      ptr_r        <= LAST_IDX;
      mask_r       <= {N{1'b0}};
      timer_r      <= {TMR_W{1'b0}};
      res_r        <= {N{1'b0}};
      tx_data_r    <= {W{1'b0}};
      tx_idx_r     <= {IDX_W{1'b0}};
      tx_valid_r   <= 1'b0;
      busy_r       <= 1'b0;
      report_cnt_r <= 16'h0000;
      clr_err_r    <= 1'b0;
    end else begin
      res_r  <= {N{1'b0}};
      // A timed-out module stays masked only until its found is seen low once
      mask_r <= mask_r & found;
      case (state_r)
        IDLE: begin
          if (grant_vld_s) begin
            tx_data_r  <= slice_s;
            tx_idx_r   <= grant_s;
            tx_valid_r <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= SEND;
          end
        end
        SEND: begin
          if (tx_valid_r && tx.tx_ready) begin
            tx_valid_r   <= 1'b0;
            report_cnt_r <= (report_cnt_r == 16'hFFFF) ? report_cnt_r : report_cnt_r + 16'd1;
            state_r      <= RELEASE;
          end
        end
        RELEASE: begin
          res_r   <= ONE_HOT0 << tx_idx_r;
          ptr_r   <= tx_idx_r;
          timer_r <= {TMR_W{1'b0}};
          state_r <= WAIT_CLR;
        end
        WAIT_CLR: begin
          if (!found_g_s) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (timer_r == TMR_LAST) begin
            clr_err_r <= 1'b1;
            mask_r    <= (mask_r & found) | (ONE_HOT0 << tx_idx_r);
            busy_r    <= 1'b0;
            state_r   <= IDLE;
          end else begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        default: begin
          tx_valid_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign res         = res_r;
  assign tx.tx_data  = tx_data_r;
  assign tx.tx_idx   = tx_idx_r;
  assign tx.tx_valid = tx_valid_r;
  assign busy        = busy_r;
  assign report_cnt  = report_cnt_r;
  assign clr_err     = clr_err_r;
endmodule

// File: tb/tb_found_scheduler.sv
// Scoreboard bench for found_scheduler: directed requests, a simple search-module
// model that drops found after res, and a monitor that checks every report.
module tb_found_scheduler;
  localparam int N     = 30;
  localparam int TAPS  = 8;
  localparam int W     = TAPS * 8;
  localparam int IDX_W = 6;
  localparam int TO    = 255;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     data;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   found;
  logic [N*W-1:0] co_buf;
  logic [N-1:0]   res;
  logic           busy;
  logic [15:0]    report_cnt;
  logic           clr_err;

  found_scheduler_if #(.W(W), .IDX_W(IDX_W)) tx_if ();

  found_scheduler #(
    .NUM_OF_TAPS(TAPS), .NUM_OF_MODULES(N), .IDX_W(IDX_W), .CLR_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .found(found), .co_buf(co_buf), .res(res),
    .tx(tx_if.master), .busy(busy), .report_cnt(report_cnt), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t exp_q[$];
  int   clr_cnt[N];
  bit   stuck[N];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] sl(input int i);
    return {16'hC0DE, 16'(i), 16'h5A5A, 16'(i) ^ 16'hFFFF};
  endfunction

  task automatic set_slice(input int i, input logic [63:0] v);
    co_buf[i*W +: W] = v;
  endtask

  task automatic push(input int i, input logic [63:0] v);
    exp_t e;
    e.idx  = IDX_W'(i);
    e.data = v;
    exp_q.push_back(e);
  endtask

  // One cycle; search-module model drops found two cycles after its res pulse
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (res[i] && !stuck[i]) begin
        clr_cnt[i] = 2;
      end else if (clr_cnt[i] > 0) begin
        clr_cnt[i]--;
        if (clr_cnt[i] == 0) found[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) clr_cnt[i] = 0;
  endtask

  task automatic wait_done(input string name, input logic [15:0] target, input int budget);
    int n = 0;
    while (!(report_cnt == target && !busy && found == '0) && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(report_cnt), 64'(target));
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!tx_if.tx_valid && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(tx_if.tx_valid), 64'd1);
  endtask

  // Monitor: compares every accepted report and the res pulse that must follow it
  logic [N-1:0] rel_exp;
  bit           rel_pend = 1'b0;
  int           rel_age  = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        rel_pend = 1'b0;
      end else begin
        if (res != '0) begin
          if (rel_pend) check("res_onehot", 64'(res), 64'(rel_exp));
          else          check("res_spurious", 64'(res), 64'd0);
          rel_pend = 1'b0;
        end else if (rel_pend) begin
          rel_age++;
          if (rel_age > 2) begin
            check("res_missing", 64'(res), 64'(rel_exp));
            rel_pend = 1'b0;
          end
        end
        if (tx_if.tx_valid && tx_if.tx_ready) begin
          if (exp_q.size() == 0) begin
            check("tx_unexpected_idx", 64'(tx_if.tx_idx), 64'hFFFF);
          end else begin
            e = exp_q.pop_front();
            check("tx_idx", 64'(tx_if.tx_idx), 64'(e.idx));
            check("tx_data", tx_if.tx_data, e.data);
            rel_exp  = {{(N-1){1'b0}}, 1'b1} << e.idx;
            rel_pend = 1'b1;
            rel_age  = 0;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int           n;
    logic [63:0]  a;
    rst = 1'b1;
    found = '0;
    tx_if.tx_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      set_slice(i, sl(i));
      clr_cnt[i] = 0;
      stuck[i]   = 1'b0;
    end
    tick();
    do_reset();

    // 1: idle after reset
    check("rst_tx_data", tx_if.tx_data, 64'd0);
    check("rst_tx_idx", 64'(tx_if.tx_idx), 64'd0);
    check("rst_clr_err", 64'(clr_err), 64'd0);
    for (int k = 0; k < 20; k++) tick();
    check("idle_tx_valid", 64'(tx_if.tx_valid), 64'd0);
    check("idle_res", 64'(res), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_report_cnt", 64'(report_cnt), 64'd0);

    // 2: single requester, one-cycle capture latency
    set_slice(3, 64'hDEAD_BEEF_0123_4567);
    push(3, 64'hDEAD_BEEF_0123_4567);
    found[3] = 1'b1;
    tick();
    check("t2_latency_valid", 64'(tx_if.tx_valid), 64'd1);
    check("t2_latency_idx", 64'(tx_if.tx_idx), 64'd3);
    wait_done("t2_report_cnt", 16'd1, 50);
    set_slice(3, sl(3));

    // 3: all requesting, fair rotation from index 0, module 0 re-requests
    do_reset();
    check("t3_cnt_after_rst", 64'(report_cnt), 64'd0);
    for (int i = 0; i < N; i++) push(i, sl(i));
    push(0, sl(0));
    found = '1;
    n = 0;
    while (found[0] && n < 50) begin
      tick();
      n++;
    end
    check("t3_found0_dropped", 64'(found[0]), 64'd0);
    tick();
    found[0] = 1'b1;
    wait_done("t3_report_cnt", 16'd31, 800);
    check("t3_queue_drained", 64'(exp_q.size()), 64'd0);

    // 4: back-pressure holds captured data while co_buf changes
    tx_if.tx_ready = 1'b0;
    a = 64'h0123_4567_89AB_CDEF;
    set_slice(5, a);
    push(5, a);
    found[5] = 1'b1;
    wait_valid("t4_valid_rise", 10);
    for (int k = 0; k < 10; k++) begin
      set_slice(5, a ^ 64'(k + 1));
      tick();
      check("t4_hold_valid", 64'(tx_if.tx_valid), 64'd1);
      check("t4_hold_data", tx_if.tx_data, a);
      check("t4_hold_res", 64'(res), 64'd0);
    end
    tx_if.tx_ready = 1'b1;
    wait_done("t4_report_cnt", 16'd32, 50);
    set_slice(5, sl(5));

    // 5: module 7 never drops found -> timeout, masked, others still served
    do_reset();
    stuck[7] = 1'b1;
    push(7, sl(7));
    found[7] = 1'b1;
    n = 0;
    while (!res[7] && n < 20) begin
      tick();
      n++;
    end
    check("t5_res7", 64'(res[7]), 64'd1);
    n = 0;
    while (!clr_err && n < 400) begin
      tick();
      n++;
    end
    check("t5_timeout_cycles", 64'(n), 64'd255);
    check("t5_idle_after_to", 64'(busy), 64'd0);
    push(9, sl(9));
    push(2, sl(2));
    found[9] = 1'b1;
    found[2] = 1'b1;
    n = 0;
    while (!(report_cnt == 16'd3 && !busy && found[9] == 1'b0 && found[2] == 1'b0) && n < 100) begin
      tick();
      n++;
    end
    check("t5_report_cnt", 64'(report_cnt), 64'd3);
    for (int k = 0; k < 10; k++) tick();
    check("t5_no_regrant", 64'(busy), 64'd0);
    check("t5_clr_err_sticky", 64'(clr_err), 64'd1);
    found[7] = 1'b0;
    stuck[7] = 1'b0;
    tick();

    // 6: reset during SEND aborts the grant and restores ptr to N-1
    tx_if.tx_ready = 1'b0;
    found[4] = 1'b1;
    wait_valid("t6_valid_rise", 10);
    check("t6_busy_send", 64'(busy), 64'd1);
    rst = 1'b1;
    found[1] = 1'b1;
    tick();
    check("t6_rst_valid", 64'(tx_if.tx_valid), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_res", 64'(res), 64'd0);
    push(1, sl(1));
    push(4, sl(4));
    rst = 1'b0;
    tx_if.tx_ready = 1'b1;
    wait_done("t6_report_cnt", 16'd2, 100);
    check("final_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
